// File: rtl/echo_filter_pkg.sv
// Shared types and constants for the echo-width smoothing filter.
// Cycle constants assume the 12 MHz HFOSC clock.
package echo_filter_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SEED  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int unsigned CLK_HZ        = 12_000_000;
  localparam int unsigned CYCLES_PER_CM = 696;
  localparam int unsigned REJECT_LIMIT  = 3;

endpackage

// File: rtl/echo_filter_if.sv
// Sample-in / filtered-echo-out bundle between the sensor front end and the display converter.
// No flow control beyond in_ready: the producer fires single-cycle pulses and never waits.
interface echo_filter_if;

  logic        in_valid;
  logic [31:0] in_cycles;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_cycles;
  logic        out_of_range;
  logic        primed;

  modport master (
    output in_valid, in_cycles,
    input  in_ready, out_valid, out_cycles, out_of_range, primed
  );

  modport slave (
    input  in_valid, in_cycles,
    output in_ready, out_valid, out_cycles, out_of_range, primed
  );

endinterface

// File: rtl/echo_ring.sv
// DEPTH x 32 circular sample buffer; every write lands at wr_ptr and advances it, wrapping.
// old_dat is combinational from the entry about to be overwritten; no backpressure.
module echo_ring #(
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [31:0]           wr_dat,
  output logic [LOG2_DEPTH-1:0] wr_ptr,
  output logic [31:0]           old_dat
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  assign old_dat = mem[wr_ptr];

endmodule

// File: rtl/echo_filter.sv
// Power-of-two moving average of clamped echo widths; 2-cycle in_valid->out_valid latency in RUN.
// in_ready drops for DEPTH cycles while seeding; pulses then are lost. Optional: ECHO_SPIKE_REJECT_EN.
module echo_filter
  import echo_filter_pkg::*;
#(
  parameter int          LOG2_DEPTH   = 3,
  parameter int unsigned MAX_CYCLES   = 278400,
  parameter int unsigned SPIKE_THRESH = 20880
) (
  input  logic               clk,
  input  logic               reset,
  echo_filter_if.slave       bus
);

  localparam int          SW    = 32 + LOG2_DEPTH;
  localparam logic [31:0] MAX_W = 32'(MAX_CYCLES);

  state_t                  state_q, state_d;
  logic [SW-1:0]           sum_q;
  logic [31:0]             seed_q;
  logic [31:0]             out_cycles_q;
  logic                    out_valid_q;
  logic                    oor_q;
  logic                    pend_q;

  logic                    acc;
  logic                    take;
  logic                    spike;
  logic                    raw_oor;
  logic [31:0]             s;
  logic                    ring_we;
  logic [31:0]             ring_wdat;
  logic [31:0]             ring_old;
  logic [LOG2_DEPTH-1:0]   ring_ptr;
  logic                    seed_done;

  assign raw_oor = bus.in_cycles > MAX_W;
  assign s       = raw_oor ? MAX_W : bus.in_cycles;
  assign acc     = bus.in_valid & bus.in_ready;
  assign take    = acc & ~spike;

  // The last seeding write is the one that wraps the ring pointer back to 0.
  assign seed_done = (state_q == SEED) && (&ring_ptr);

`ifdef ECHO_SPIKE_REJECT_EN
  logic [31:0] dist;
  logic [1:0]  rej_q;

  assign dist  = (s > out_cycles_q) ? (s - out_cycles_q) : (out_cycles_q - s);
  assign spike = (state_q == RUN) && (dist > 32'(SPIKE_THRESH)) && (rej_q < 2'(REJECT_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      rej_q <= '0;
    end else if (acc && state_q == RUN) begin
      rej_q <= spike ? rej_q + 2'd1 : 2'd0;
    end
  end
`else
  assign spike = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ring_we   = 1'b0;
    ring_wdat = s;
    case (state_q)
      EMPTY: begin
        if (acc) state_d = SEED;
      end
      SEED: begin
        ring_we   = 1'b1;
        ring_wdat = seed_q;
        if (seed_done) state_d = RUN;
      end
      RUN: begin
        ring_we = take;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q        <= '0;
      seed_q       <= '0;
      out_cycles_q <= '0;
      out_valid_q  <= 1'b0;
      oor_q        <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      // Average is taken one edge after the sum update so it sees the new sample.
      if (pend_q) begin
        out_cycles_q <= sum_q[LOG2_DEPTH +: 32];
        out_valid_q  <= 1'b1;
      end
      if (seed_done) begin
        out_cycles_q <= seed_q;
        out_valid_q  <= 1'b1;
      end
      if (acc) begin
        oor_q <= raw_oor;
      end
      if (state_q == EMPTY && acc) begin
        sum_q  <= SW'(s) << LOG2_DEPTH;
        seed_q <= s;
      end
      if (state_q == RUN && take) begin
        sum_q  <= sum_q - SW'(ring_old) + SW'(s);
        pend_q <= 1'b1;
      end
    end
  end

  echo_ring #(
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (ring_we),
    .wr_dat  (ring_wdat),
    .wr_ptr  (ring_ptr),
    .old_dat (ring_old)
  );

  assign bus.in_ready     = (state_q != SEED);
  assign bus.primed       = (state_q == RUN);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_cycles   = out_cycles_q;
  assign bus.out_of_range = oor_q;

endmodule
